// File: rtl/ppl_pkg.sv
// Shared pipeline definitions: ALU operation codes and execute-stage FSM encoding.
// Used by the decode control unit and by the execute stage.
package ppl_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [1:0] {
        EXE_IDLE = 2'd0,
        EXE_BUSY = 2'd1,
        EXE_DONE = 2'd2
    } exe_state_e;

endpackage

// File: rtl/ppl_mul_iter.sv
// Iterative shift-add multiplier: 32 iterations, keeps the low WIDTH bits of a*b (unsigned).
// done is high during the final iteration so the owner can step its FSM on the same edge.
module ppl_mul_iter
    import ppl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] prod_r;
    logic [4:0]       cnt_r;
    logic             busy_r;

    // Load operands on start, then one conditional add and shift per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            prod_r   <= '0;
            cnt_r    <= 5'd0;
            busy_r   <= 1'b0;
        end else if (start && !busy_r) begin
            mcand_r  <= a;
            mplier_r <= b;
            prod_r   <= '0;
            cnt_r    <= 5'd0;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            if (mplier_r[0]) begin
                prod_r <= prod_r + mcand_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + 5'd1;
            if (cnt_r == 5'd31) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = busy_r && (cnt_r == 5'd31);
    assign product = prod_r;

endmodule

// File: rtl/ppl_exe_stage.sv
// MIPS execute stage: operand muxing, ALU/shift/jal result, EX/MEM registers,
// and a multi-cycle MUL sequence that stalls upstream while it iterates.
module ppl_exe_stage
    import ppl_pkg::*;
#(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] MUL_CODE = ALU_MUL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exWriteReg,
    input  logic             exMem2Reg,
    input  logic             exWriteMem,
    input  logic             exJal,
    input  logic             exAluImm,
    input  logic             exShift,
    input  logic [3:0]       exAluC,
    input  logic [WIDTH-1:0] expc4,
    input  logic [WIDTH-1:0] exDataA,
    input  logic [WIDTH-1:0] exDataB,
    input  logic [WIDTH-1:0] exDataImm,
    input  logic [4:0]       exReg0,
    output logic             stall,
    output logic             mWriteReg,
    output logic             mMem2Reg,
    output logic             mWriteMem,
    output logic [WIDTH-1:0] mAluR,
    output logic [WIDTH-1:0] mDataB,
    output logic [4:0]       mReg
);

    exe_state_e       state_r;
    logic             post_rst_r;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH-1:0] alu_s;
    logic [WIDTH-1:0] result_s;
    logic [WIDTH-1:0] mul_product_s;
    logic             mul_busy_s;
    logic             mul_done_s;
    logic             is_mul_s;
    logic             start_s;

    assign op_a_s   = exShift  ? {{(WIDTH-5){1'b0}}, exDataImm[10:6]} : exDataA;
    assign op_b_s   = exAluImm ? exDataImm : exDataB;
    assign is_mul_s = (exAluC == MUL_CODE);

    // A MUL seen in the cycle right after reset is not started, so stall stays low there.
    assign start_s = !reset && !post_rst_r && (state_r == EXE_IDLE) && is_mul_s;
    assign stall   = !reset && (start_s || mul_busy_s);

    ppl_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (start_s),
        .a       (op_a_s),
        .b       (op_b_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // ALU operation decode; unlisted codes behave as add.
    always_comb begin
        alu_s = op_a_s + op_b_s;
        case (exAluC)
            ALU_ADD:  alu_s = op_a_s + op_b_s;
            ALU_SUB:  alu_s = op_a_s - op_b_s;
            ALU_AND:  alu_s = op_a_s & op_b_s;
            ALU_OR:   alu_s = op_a_s | op_b_s;
            ALU_XOR:  alu_s = op_a_s ^ op_b_s;
            ALU_LUI:  alu_s = op_b_s << 16;
            ALU_SLL:  alu_s = op_b_s << op_a_s[4:0];
            ALU_SRL:  alu_s = op_b_s >> op_a_s[4:0];
            ALU_SRA:  alu_s = $unsigned($signed(op_b_s) >>> op_a_s[4:0]);
            MUL_CODE: alu_s = mul_product_s;
            default:  alu_s = op_a_s + op_b_s;
        endcase
    end

    assign result_s = exJal ? expc4 : alu_s;

    // FSM and EX/MEM boundary registers; bubbles are issued while a MUL is in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= EXE_IDLE;
            post_rst_r <= 1'b1;
            mWriteReg  <= 1'b0;
            mMem2Reg   <= 1'b0;
            mWriteMem  <= 1'b0;
            mAluR      <= '0;
            mDataB     <= '0;
            mReg       <= 5'd0;
        end else begin
            post_rst_r <= 1'b0;
            case (state_r)
                EXE_IDLE: begin
                    if (is_mul_s) begin
                        mWriteReg <= 1'b0;
                        mMem2Reg  <= 1'b0;
                        mWriteMem <= 1'b0;
                        mAluR     <= '0;
                        mDataB    <= '0;
                        mReg      <= 5'd0;
                        state_r   <= post_rst_r ? EXE_IDLE : EXE_BUSY;
                    end else begin
                        mWriteReg <= exWriteReg;
                        mMem2Reg  <= exMem2Reg;
                        mWriteMem <= exWriteMem;
                        mAluR     <= result_s;
                        mDataB    <= exDataB;
                        mReg      <= exReg0;
                        state_r   <= EXE_IDLE;
                    end
                end
                EXE_BUSY: begin
                    mWriteReg <= 1'b0;
                    mMem2Reg  <= 1'b0;
                    mWriteMem <= 1'b0;
                    mAluR     <= '0;
                    mDataB    <= '0;
                    mReg      <= 5'd0;
                    state_r   <= mul_done_s ? EXE_DONE : EXE_BUSY;
                end
                EXE_DONE: begin
                    mWriteReg <= exWriteReg;
                    mMem2Reg  <= exMem2Reg;
                    mWriteMem <= exWriteMem;
                    mAluR     <= result_s;
                    mDataB    <= exDataB;
                    mReg      <= exReg0;
                    state_r   <= EXE_IDLE;
                end
                default: begin
                    mWriteReg <= 1'b0;
                    mMem2Reg  <= 1'b0;
                    mWriteMem <= 1'b0;
                    mAluR     <= '0;
                    mDataB    <= '0;
                    mReg      <= 5'd0;
                    state_r   <= EXE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ppl_exe_stage.md
Name: ppl_exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the ID/EX register outputs (ex* signals) and computes the ALU or shift result, or the jal link value.
- Registers the result and the surviving control signals into the EX/MEM boundary (m* outputs).
- Contains an iterative 32-cycle shift-add multiplier for MUL. While it runs, the block raises stall to freeze the upstream stages, and the EX/MEM boundary receives bubbles.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; the multiplier counter is sized for it.
- MUL_CODE, 4'b1000, AluC encoding that selects the multi-cycle multiply.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- exWriteReg  in  1  register-file write enable for this instruction
- exMem2Reg  in  1  writeback selects memory data
- exWriteMem  in  1  data-memory store enable
- exJal  in  1  jal: the result is the link address
- exAluImm  in  1  ALU operand B is exDataImm instead of exDataB
- exShift  in  1  ALU operand A is the shift amount exDataImm[10:6], zero-extended
- exAluC  in  4  ALU operation code
- expc4  in  32  link value from the ID stage
- exDataA  in  32  operand A
- exDataB  in  32  operand B, also the store data
- exDataImm  in  32  extended immediate
- exReg0  in  5  destination register number
- stall  out  1  combinational; 1 means upstream must hold PC, IF/ID and ID/EX
- mWriteReg, mMem2Reg, mWriteMem  out  1 each  registered controls to MEM
- mAluR  out  32  registered result
- mDataB  out  32  registered store data
- mReg  out  5  registered destination register

Behaviour:
- Operand muxes:
  - A = exShift ? {27'b0, exDataImm[10:6]} : exDataA
  - B = exAluImm ? exDataImm : exDataB
- AluC decode:
  - 0000 add
  - 0100 sub
  - 0001 and
  - 0101 or
  - 0010 xor
  - 0110 lui (B<<16)
  - 0011 sll (B<<A[4:0])
  - 0111 srl
  - 1111 sra
  - MUL_CODE: low 32 bits of A*B, unsigned
  - any other code: add
- Add and sub wrap modulo 2^32; no overflow detection.
- Result = exJal ? expc4 : ALU output.
- FSM states: IDLE, BUSY, DONE.
- IDLE, exAluC != MUL_CODE:
  - stall = 0
  - at the edge, the m* registers capture the result, the controls, exDataB and exReg0
  - single-cycle latency
- IDLE, exAluC == MUL_CODE:
  - stall = 1
  - at the edge: load multiplicand A, multiplier B, product = 0, cnt = 0, go to BUSY
  - m* gets a bubble: mWriteReg = mMem2Reg = mWriteMem = 0, mAluR = mDataB = mReg = 0
- BUSY:
  - stall = 1
  - each edge: if multiplier[0] then product += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++
  - m* gets a bubble every cycle
  - when cnt == 31 at the edge (32nd iteration), go to DONE
- DONE:
  - stall = 0, so upstream advances at this edge
  - m* captures the product with the held ex* controls
  - go to IDLE
- MUL total: 34 cycles in EX, with stall high for exactly 33 consecutive cycles.
- Upstream contract: while stall = 1, all ex* inputs are held stable. The block does not re-sample operands during BUSY.
- Back-to-back MULs: a MUL arriving in the cycle after DONE starts a fresh sequence from IDLE.
- Reset (synchronous; has priority over everything, including mid-multiply):
  - state = IDLE, cnt = 0, product = 0
  - all m* outputs = 0
  - stall = 0 in the reset cycle and in the cycle after it
  - an in-flight MUL is abandoned and no result is written
- stall depends only on state and exAluC. It has no path from m* outputs.

Decomposition:
- Shared package ppl_pkg holds:
  - AluC code constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL
  - FSM state encoding: EXE_IDLE, EXE_BUSY, EXE_DONE
- Shared by the decode control unit and this block.
- One natural sub-module: ppl_mul_iter. It holds the shift-add datapath, cnt and the done flag, with start, a, b, busy, done and product ports.
- The ALU case-decode and the EX/MEM registers stay in ppl_exe_stage.

Test Plan:
- add, AluImm=0, A=0x7FFFFFFF, B=1, exWriteReg=1, exReg0=5 -> next edge: mAluR=0x80000000, mReg=5, mWriteReg=1, stall never high.
- sra, exShift=1, exDataImm[10:6]=4, B=0x80000000 -> mAluR=0xF8000000. With AluC=srl, same operands -> mAluR=0x08000000.
- jal, exJal=1, expc4=0x00400008, AluC=add -> mAluR=0x00400008.
- MUL, A=0x00010001, B=0x0000FFFF, inputs held -> stall=1 for exactly 33 cycles; m* controls 0 in those cycles; the edge after stall falls gives mAluR=0xFFFFFFFF with captured controls.
- MUL, A=0xFFFFFFFF, B=2 -> mAluR=0xFFFFFFFE (wrap). An add presented immediately after DONE completes in 1 cycle with stall=0.
- reset=1 on the 10th BUSY cycle -> next edge: all m* = 0, stall = 0, state IDLE. A subsequent add works normally.
